cache_fill_ctrl: RTL and testbench

- Miss-handling sequencer for the 64-block x 8-word, 16-bit cache data array.
- On a cache miss it issues 8 word reads to main memory and steers each returned word into the data array using one-hot block and word enables.
- It then pulses a tag-array write and a completion strobe.
- It sits between the cache hit/miss logic, the memory port and the data/tag arrays, and owns their write-side enables while busy.

---
 rtl/cache_fill_ctrl_if.sv | 35 +++
 rtl/cache_fill_ctrl.sv | 98 +++++++++
 tb/tb_cache_fill_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_ctrl_if.sv
// Signal bundle between the miss sequencer and its neighbours: the hit/miss logic,
// the memory read port, and the data/tag array write sides.
interface cache_fill_ctrl_if #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_BLOCKS = 64,
  parameter int unsigned IDX_W      = 6
);
  logic                  miss_detected;
  logic [ADDR_W-1:0]     miss_address;
  logic [IDX_W-1:0]      miss_index;
  logic [DATA_W-1:0]     memory_data;
  logic                  memory_data_valid;
  logic                  mem_read_req;
  logic [ADDR_W-1:0]     memory_address;
  logic                  fsm_busy;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [DATA_W-1:0]     data_out;
  logic [NUM_BLOCKS-1:0] block_enable;
  logic [7:0]            word_enable;
  logic                  fill_done;

  modport slave (
    input  miss_detected, miss_address, miss_index, memory_data, memory_data_valid,
    output mem_read_req, memory_address, fsm_busy, write_data_array, write_tag_array,
           data_out, block_enable, word_enable, fill_done
  );

  modport master (
    output miss_detected, miss_address, miss_index, memory_data, memory_data_valid,
    input  mem_read_req, memory_address, fsm_busy, write_data_array, write_tag_array,
           data_out, block_enable, word_enable, fill_done
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache miss sequencer: issues 8 word reads for the missing line, steers returned
// words into the data array, then pulses the tag write and a completion strobe.
module cache_fill_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_BLOCKS = 64,
  parameter int unsigned IDX_W      = 6
) (
  input logic           clk,
  input logic           rst,
  cache_fill_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFill, StTag} state_e;

  state_e             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_base, w_base_nxt;
  logic [IDX_W-1:0]   r_index, w_index_nxt;
  logic [3:0]         r_issue_cnt, w_issue_cnt_nxt;
  logic [3:0]         r_recv_cnt, w_recv_cnt_nxt;
  logic [NUM_BLOCKS-1:0] w_blk_onehot;

  assign w_blk_onehot = {{(NUM_BLOCKS-1){1'b0}}, 1'b1} << r_index;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_index     <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_index     <= w_index_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_recv_cnt  <= w_recv_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_base_nxt           = r_base;
    w_index_nxt          = r_index;
    w_issue_cnt_nxt      = r_issue_cnt;
    w_recv_cnt_nxt       = r_recv_cnt;
    bus.mem_read_req     = 1'b0;
    bus.memory_address   = '0;
    bus.fsm_busy         = 1'b0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.data_out         = '0;
    bus.block_enable     = '0;
    bus.word_enable      = '0;
    bus.fill_done        = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.miss_detected) begin
          // Line-align: 8 words x 2 bytes = 16-byte line.
          w_base_nxt      = bus.miss_address & ~ADDR_W'(4'hF);
          w_index_nxt     = bus.miss_index;
          w_issue_cnt_nxt = '0;
          w_recv_cnt_nxt  = '0;
          w_state_nxt     = StFill;
        end
      end
      StFill: begin
        bus.fsm_busy     = 1'b1;
        bus.block_enable = w_blk_onehot;
        if (r_issue_cnt < 4'd8) begin
          bus.mem_read_req   = 1'b1;
          bus.memory_address = r_base + ADDR_W'({r_issue_cnt[2:0], 1'b0});
          w_issue_cnt_nxt    = r_issue_cnt + 4'd1;
        end
        // Returns arrive in issue order, so the receive count alone picks the word.
        if (bus.memory_data_valid && (r_recv_cnt < 4'd8)) begin
          bus.write_data_array = 1'b1;
          bus.data_out         = bus.memory_data;
          bus.word_enable      = 8'd1 << r_recv_cnt[2:0];
          w_recv_cnt_nxt       = r_recv_cnt + 4'd1;
          if (r_recv_cnt == 4'd7) begin
            w_state_nxt = StTag;
          end
        end
      end
      StTag: begin
        bus.fsm_busy        = 1'b1;
        bus.block_enable    = w_blk_onehot;
        bus.write_tag_array = 1'b1;
        bus.fill_done       = 1'b1;
        w_state_nxt         = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: fill timing, irregular returns, busy protection,
// async reset mid-fill, top-of-memory addressing and idle noise.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   npass = 0;
  int   ntotal = 0;

  cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16), .NUM_BLOCKS(64), .IDX_W(6)) bus ();

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .NUM_BLOCKS(64), .IDX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic miss, input logic [15:0] addr, input logic [5:0] idx,
                       input logic valid, input logic [15:0] data);
    bus.miss_detected     = miss;
    bus.miss_address      = addr;
    bus.miss_index        = idx;
    bus.memory_data_valid = valid;
    bus.memory_data       = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 16'h0, 6'd0, 1'b0, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 16'h0, 6'd0, 1'b0, 16'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    ntotal++;
    if ({bus.mem_read_req, bus.fsm_busy, bus.write_data_array, bus.write_tag_array,
         bus.fill_done} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {bus.mem_read_req, bus.fsm_busy,
               bus.write_data_array, bus.write_tag_array, bus.fill_done});
    else npass++;
    ntotal++;
    if (bus.block_enable !== 64'h0 || bus.word_enable !== 8'h0 || bus.data_out !== 16'h0)
      $display("FAIL reset_vec: got blk=%h we=%h do=%h want 0", bus.block_enable,
               bus.word_enable, bus.data_out);
    else npass++;
    rst = 1'b1;
  endtask

  // Miss on cycle 0, memory answers every issue 4 cycles later with 16'hA000+k.
  task automatic test_fill(input string nm, input logic [15:0] addr, input logic [5:0] idx,
                           input logic [15:0] base);
    for (int c = 0; c <= 14; c++) begin
      logic        e_req, e_busy, e_wr, e_tag;
      logic [15:0] e_addr, e_do;
      logic [7:0]  e_we;
      logic [63:0] e_blk;
      @(negedge clk);
      drive(c == 0, addr, idx, (c >= 5 && c <= 12), 16'hA000 + 16'(c - 5));
      #1;
      e_req  = (c >= 1 && c <= 8);
      e_addr = base + 16'(2 * (c - 1));
      e_busy = (c >= 1 && c <= 13);
      e_wr   = (c >= 5 && c <= 12);
      e_we   = e_wr ? (8'd1 << (c - 5)) : 8'h0;
      e_do   = e_wr ? 16'hA000 + 16'(c - 5) : 16'h0;
      e_tag  = (c == 13);
      e_blk  = e_busy ? (64'd1 << idx) : 64'h0;
      ntotal++;
      if ({bus.mem_read_req, bus.fsm_busy, bus.write_data_array, bus.write_tag_array,
           bus.fill_done} !== {e_req, e_busy, e_wr, e_tag, e_tag})
        $display("FAIL %s_ctrl c%0d: got %b want %b", nm, c, {bus.mem_read_req, bus.fsm_busy,
                 bus.write_data_array, bus.write_tag_array, bus.fill_done},
                 {e_req, e_busy, e_wr, e_tag, e_tag});
      else npass++;
      if (e_req) begin
        ntotal++;
        if (bus.memory_address !== e_addr)
          $display("FAIL %s_addr c%0d: got %h want %h", nm, c, bus.memory_address, e_addr);
        else npass++;
      end
      ntotal++;
      if (bus.word_enable !== e_we || bus.data_out !== e_do || bus.block_enable !== e_blk)
        $display("FAIL %s_wr c%0d: got we=%h do=%h blk=%h want we=%h do=%h blk=%h", nm, c,
                 bus.word_enable, bus.data_out, bus.block_enable, e_we, e_do, e_blk);
      else npass++;
    end
  endtask

  task automatic test_irregular();
    logic vpat [20];
    int k = 0;
    vpat = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    for (int c = 0; c < 20; c++) begin
      logic       e_wr, e_tag;
      logic [7:0] e_we;
      @(negedge clk);
      drive(c == 0, 16'h2222, 6'd3, vpat[c], 16'hB000 + 16'(c));
      #1;
      e_wr  = (c >= 1) && (c <= 14) && vpat[c];
      e_we  = e_wr ? (8'd1 << k) : 8'h0;
      e_tag = (c == 15);
      ntotal++;
      if (bus.write_data_array !== e_wr || bus.word_enable !== e_we)
        $display("FAIL irreg_wr c%0d: got wr=%b we=%h want wr=%b we=%h", c,
                 bus.write_data_array, bus.word_enable, e_wr, e_we);
      else npass++;
      ntotal++;
      if (bus.write_tag_array !== e_tag || bus.fill_done !== e_tag)
        $display("FAIL irreg_tag c%0d: got %b%b want %b%b", c, bus.write_tag_array,
                 bus.fill_done, e_tag, e_tag);
      else npass++;
      if (e_wr) k++;
    end
  endtask

  task automatic test_busy_protect();
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, 16'h1234, 6'd5, 1'b0, 16'h0);
      else drive(c >= 3 && c <= 14, 16'h4000, 6'd9, (c >= 5 && c <= 12), 16'h0);
      #1;
      if (c >= 3 && c <= 13) begin
        ntotal++;
        if (bus.block_enable !== (64'd1 << 5) || bus.fsm_busy !== 1'b1)
          $display("FAIL busy_blk c%0d: got blk=%h busy=%b want blk=%h busy=1", c,
                   bus.block_enable, bus.fsm_busy, 64'd1 << 5);
        else npass++;
      end
      if (c == 13) begin
        ntotal++;
        if (bus.fill_done !== 1'b1)
          $display("FAIL busy_done: got %b want 1", bus.fill_done);
        else npass++;
      end
      if (c == 14) begin
        ntotal++;
        if (bus.fsm_busy !== 1'b0 || bus.block_enable !== 64'h0)
          $display("FAIL busy_idle: got busy=%b blk=%h want 0", bus.fsm_busy,
                   bus.block_enable);
        else npass++;
      end
      if (c == 15) begin
        ntotal++;
        if (bus.mem_read_req !== 1'b1 || bus.memory_address !== 16'h4000 ||
            bus.block_enable !== (64'd1 << 9))
          $display("FAIL busy_accept: got req=%b addr=%h blk=%h want 1 4000 %h",
                   bus.mem_read_req, bus.memory_address, bus.block_enable, 64'd1 << 9);
        else npass++;
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_fill();
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      drive(c == 0, 16'h1234, 6'd5, (c >= 5), 16'hA000 + 16'(c));
      #1;
      if (c >= 5) begin
        ntotal++;
        if (bus.write_data_array !== 1'b1 || bus.word_enable !== (8'd1 << (c - 5)))
          $display("FAIL rst_pre c%0d: got wr=%b we=%h want 1 %h", c, bus.write_data_array,
                   bus.word_enable, 8'd1 << (c - 5));
        else npass++;
      end
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 6'd0, 1'b1, 16'hA008);
    rst = 1'b0;
    #1;
    ntotal++;
    if ({bus.mem_read_req, bus.fsm_busy, bus.write_data_array, bus.write_tag_array,
         bus.fill_done} !== 5'b0 || bus.block_enable !== 64'h0 || bus.word_enable !== 8'h0 ||
        bus.data_out !== 16'h0)
      $display("FAIL rst_async: got ctrl=%b blk=%h we=%h do=%h want 0",
               {bus.mem_read_req, bus.fsm_busy, bus.write_data_array, bus.write_tag_array,
                bus.fill_done}, bus.block_enable, bus.word_enable, bus.data_out);
    else npass++;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b0, 16'h0, 6'd0, 1'b1, 16'hC000);
      #1;
      ntotal++;
      if ({bus.mem_read_req, bus.fsm_busy, bus.write_data_array, bus.write_tag_array,
           bus.fill_done} !== 5'b0)
        $display("FAIL rst_after c%0d: got %b want 00000", c, {bus.mem_read_req,
                 bus.fsm_busy, bus.write_data_array, bus.write_tag_array, bus.fill_done});
      else npass++;
    end
  endtask

  task automatic test_idle_noise();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b0, 16'h5678, 6'd7, c[0], 16'hDEAD);
      #1;
      ntotal++;
      if (bus.write_data_array !== 1'b0 || bus.block_enable !== 64'h0 ||
          bus.word_enable !== 8'h0 || bus.fsm_busy !== 1'b0)
        $display("FAIL idle_noise c%0d: got wr=%b blk=%h we=%h busy=%b want 0", c,
                 bus.write_data_array, bus.block_enable, bus.word_enable, bus.fsm_busy);
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill("basic", 16'h1234, 6'd5, 16'h1230);
    test_irregular();
    do_reset();
    test_busy_protect();
    test_reset_mid_fill();
    test_fill("top", 16'hFFFF, 6'd63, 16'hFFF0);
    test_idle_noise();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
